// File: rtl/sr_trace_tx.sv
// Retired-instruction trace serializer: buffers {a0, instr, pc} records in a small FIFO
// and ships each as an 8N1 UART frame. Define SR_TRACE_CHECKSUM_EN to append an XOR checksum byte.
module sr_trace_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trace_valid,
  input  logic [31:0] trace_pc,
  input  logic [31:0] trace_instr,
  input  logic [31:0] trace_a0,
  output logic        uart_tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);
`ifdef SR_TRACE_CHECKSUM_EN
  localparam logic [3:0] LAST_BYTE = 4'd13;
`else
  localparam logic [3:0] LAST_BYTE = 4'd12;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, stateNext;
  logic [95:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [PW:0]     count;
  logic [95:0]     frame;
  logic [3:0]      byteIdx;
  logic [2:0]      bitIdx;
  logic [15:0]     bitCnt;
  logic            pop, push, bitDone;
  logic [7:0]      curByte;

  assign bitDone   = (bitCnt == 16'd0);
  assign fifo_full = (count == (PW+1)'(FIFO_DEPTH));
  assign pop       = (state == IDLE) && (count != '0);
  // A full FIFO still accepts when the FSM drains an entry on the same edge.
  assign push      = trace_valid && (!fifo_full || pop);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= {trace_a0, trace_instr, trace_pc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (trace_valid && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (count != '0) stateNext = START;
      START:   if (bitDone) stateNext = DATA;
      DATA:    if (bitDone && bitIdx == 3'd7) stateNext = STOP;
      STOP:    if (bitDone) stateNext = (byteIdx == LAST_BYTE) ? IDLE : START;
      default: stateNext = IDLE;
    endcase
  end

  // Bit timer reloads on every boundary, so bit periods never drift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame   <= '0;
      byteIdx <= '0;
      bitIdx  <= '0;
      bitCnt  <= '0;
    end else if (state == IDLE) begin
      if (pop) begin
        frame   <= mem[rdPtr];
        byteIdx <= '0;
        bitIdx  <= '0;
        bitCnt  <= BIT_RELOAD;
      end
    end else begin
      bitCnt <= bitDone ? BIT_RELOAD : bitCnt - 16'd1;
      if (state == DATA && bitDone) bitIdx <= bitIdx + 3'd1;
      if (state == STOP && bitDone && byteIdx != LAST_BYTE) byteIdx <= byteIdx + 4'd1;
    end
  end

`ifdef SR_TRACE_CHECKSUM_EN
  logic [7:0]   checksum;
  logic [111:0] frameBytes;
  always_comb begin
    checksum = '0;
    for (int i = 0; i < 12; i++) checksum = checksum ^ frame[i*8 +: 8];
  end
  assign frameBytes = {checksum, frame, 8'hA5};
`else
  logic [103:0] frameBytes;
  assign frameBytes = {frame, 8'hA5};
`endif

  assign curByte = 8'(frameBytes >> {byteIdx, 3'b000});

  always_comb begin
    case (state)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = curByte[bitIdx];
      default: uart_tx = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_sr_trace_tx.sv
// Bench for sr_trace_tx: frame-level reference model checked every cycle, a serial
// receiver decoding the line, and directed scenarios for FIFO, overflow and reset behaviour.
module tb_sr_trace_tx;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
`ifdef SR_TRACE_CHECKSUM_EN
  localparam int NBYTES = 14;
  localparam int BUSY_LIT = 560;
`else
  localparam int NBYTES = 13;
  localparam int BUSY_LIT = 520;
`endif
  localparam int FRAME_CYC = NBYTES * 10 * CLK_DIV;

  logic clk = 1'b0, rst_n = 1'b0, trace_valid = 1'b0;
  logic [31:0] trace_pc = '0, trace_instr = '0, trace_a0 = '0;
  logic uart_tx, busy, fifo_full, overflow;

  sr_trace_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_instr(trace_instr), .trace_a0(trace_a0), .uart_tx(uart_tx), .busy(busy),
    .fifo_full(fifo_full), .overflow(overflow));

  always #5 clk = ~clk;

  int nChecks = 0, nPass = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: record queue plus remaining-cycles counter of the frame on the wire.
  logic [95:0] mq[$];
  int          mLeft = 0;
  bit          mOvf  = 1'b0;
  logic [95:0] mRec  = '0;
  logic [7:0]  expQ[$], rxQ[$];
  int          busyCycles = 0;

  function automatic logic [7:0] frameByte(logic [95:0] r, int i);
    logic [7:0] x;
    if (i == 0) return 8'hA5;
    if (i <= 12) return r[(i-1)*8 +: 8];
    x = '0;
    for (int k = 0; k < 12; k++) x ^= r[k*8 +: 8];
    return x;
  endfunction

  function automatic logic expTx();
    int off, bn, pos;
    logic [7:0] b;
    if (mLeft == 0) return 1'b1;
    off = FRAME_CYC - mLeft;
    bn  = off / CLK_DIV;
    pos = bn % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    b = frameByte(mRec, bn / 10);
    return b[pos-1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mLeft = 0;
      mOvf  = 1'b0;
    end else begin
      bit idle, doPop, acc;
      idle  = (mLeft == 0);
      doPop = idle && (mq.size() > 0);
      acc   = trace_valid && (mq.size() < DEPTH || doPop);
      if (trace_valid && !acc) mOvf = 1'b1;
      if (mLeft > 0) mLeft--;
      if (doPop) begin
        mRec  = mq.pop_front();
        mLeft = FRAME_CYC;
        for (int i = 0; i < NBYTES; i++) expQ.push_back(frameByte(mRec, i));
      end
      if (acc) mq.push_back({trace_a0, trace_instr, trace_pc});
    end
  end

  always @(negedge clk) begin
    chk("uart_tx", {31'd0, uart_tx}, {31'd0, expTx()});
    chk("busy", {31'd0, busy}, {31'd0, mLeft > 0});
    chk("fifo_full", {31'd0, fifo_full}, {31'd0, mq.size() == DEPTH});
    chk("overflow", {31'd0, overflow}, {31'd0, mOvf});
    if (busy) busyCycles++;
  end

  // Serial receiver: samples each bit at the first cycle of its period.
  logic [7:0] rxB;
  always begin
    @(negedge clk);
    if (rst_n && uart_tx === 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(negedge clk);
        rxB[i] = uart_tx;
      end
      repeat (CLK_DIV) @(negedge clk);
      rxQ.push_back(rxB);
    end
  end

  task automatic push(logic [31:0] pc, logic [31:0] instr, logic [31:0] a0);
    trace_valid = 1'b1; trace_pc = pc; trace_instr = instr; trace_a0 = a0;
    @(posedge clk); #1;
    trace_valid = 1'b0;
  endtask

  task automatic waitIdle(int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (mLeft == 0 && mq.size() == 0) break;
    end
    chk("idle_timeout", {31'd0, i < budget}, 32'd1);
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cmpRx(string nm, logic [95:0] recs[$]);
    chk({nm, "_len"}, rxQ.size(), recs.size() * NBYTES);
    for (int k = 0; k < recs.size(); k++)
      for (int j = 0; j < NBYTES; j++)
        if (k*NBYTES + j < rxQ.size())
          chk(nm, {24'd0, rxQ[k*NBYTES + j]}, {24'd0, frameByte(recs[k], j)});
  endtask

  logic [7:0]  gold [14] = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05,
                             8'hA0, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'hAC};
  logic [95:0] recs[$];
  int          lows, i;

  initial begin
    #3;
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_full", {31'd0, fifo_full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single known record; inputs scrambled right after the push.
    rxQ.delete(); busyCycles = 0;
    push(32'h00000010, 32'h00a00513, 32'h0000000a);
    trace_pc = $urandom; trace_instr = $urandom; trace_a0 = $urandom;
    waitIdle(FRAME_CYC + 50);
    chk("gold_len", rxQ.size(), NBYTES);
    for (int j = 0; j < NBYTES; j++)
      if (j < rxQ.size()) chk("gold_byte", {24'd0, rxQ[j]}, {24'd0, gold[j]});
    chk("busy_len", busyCycles, BUSY_LIT);

    // Six back-to-back pushes into depth-4 FIFO: one popped, four queued, one dropped.
    rxQ.delete(); recs.delete();
    for (int k = 0; k < 6; k++) recs.push_back({$urandom, $urandom, $urandom});
    for (int k = 0; k < 6; k++) push(recs[k][31:0], recs[k][63:32], recs[k][95:64]);
    chk("burst_full", {31'd0, fifo_full}, 32'd1);
    chk("burst_ovf", {31'd0, overflow}, 32'd1);
    waitIdle(6 * FRAME_CYC);
    recs.pop_back();
    cmpRx("burst_frame", recs);
    doReset();
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO accepts a record on the same edge the FSM pops.
    rxQ.delete(); recs.delete();
    for (int k = 0; k < 6; k++) recs.push_back({$urandom, $urandom, $urandom});
    for (int k = 0; k < 5; k++) push(recs[k][31:0], recs[k][63:32], recs[k][95:64]);
    for (i = 0; i < 2 * FRAME_CYC; i++) begin
      @(posedge clk); #1;
      if (mLeft == 0 && mq.size() == DEPTH) break;
    end
    chk("full_wait", {31'd0, i < 2 * FRAME_CYC}, 32'd1);
    chk("full_before", {31'd0, fifo_full}, 32'd1);
    push(recs[5][31:0], recs[5][63:32], recs[5][95:64]);
    chk("full_pop_ovf", {31'd0, overflow}, 32'd0);
    chk("full_pop_full", {31'd0, fifo_full}, 32'd1);
    waitIdle(7 * FRAME_CYC);
    cmpRx("pushpop_frame", recs);

    // Reset during data bit 3 of byte 5.
    push(32'h00000010, 32'h00a00513, 32'h0000000a);
    for (i = 0; i < FRAME_CYC; i++) begin
      if (mLeft == FRAME_CYC - (5*10 + 4) * CLK_DIV - 1) break;
      @(posedge clk); #1;
    end
    chk("mid_wait", {31'd0, i < FRAME_CYC}, 32'd1);
    chk("mid_tx_before", {31'd0, uart_tx}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    #10 rst_n = 1'b1;
    lows = 0;
    repeat (1000) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("post_rst_quiet", lows, 0);

    // Randomized traffic against the model.
    @(posedge clk); #1;
    rxQ.delete(); expQ.delete();
    repeat (4000) begin
      trace_valid = ($urandom_range(0, 39) == 0);
      trace_pc = $urandom; trace_instr = $urandom; trace_a0 = $urandom;
      @(posedge clk); #1;
    end
    trace_valid = 1'b0;
    waitIdle((DEPTH + 2) * FRAME_CYC);
    chk("rand_len", rxQ.size(), expQ.size());
    for (int j = 0; j < rxQ.size() && j < expQ.size(); j++)
      chk("rand_byte", {24'd0, rxQ[j]}, {24'd0, expQ[j]});

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
